// File: rtl/prbs_gen_chk_if.sv
// ---------------------------------------------------------------------------
// prbs_gen_chk_if
// Groups the generator and checker signals of prbs_gen_chk.
//   master : the user side (drives enable/inj_err and the received stream)
//   slave  : the prbs_gen_chk block itself
// Signals:
//   enable    - generator advances one word per cycle while high
//   inj_err   - pulse: invert bit WIDTH-1 of the next generated word
//   gen_data  - generated word, bit WIDTH-1 first in time
//   gen_valid - gen_data holds a new word
//   chk_data  - received word, bit WIDTH-1 first in time
//   chk_valid - chk_data valid this cycle
//   clr_cnt   - clear err_cnt
//   locked    - checker in LOCKED state
//   err_cnt   - saturating errored-bit count (LOCKED only)
//   err_pulse - last checked word had at least one error
// ---------------------------------------------------------------------------
interface prbs_gen_chk_if #(
   parameter int WIDTH     = 1,
   parameter int ERR_CNT_W = 16
);
   logic                 enable;
   logic                 inj_err;
   logic [WIDTH-1:0]     gen_data;
   logic                 gen_valid;
   logic [WIDTH-1:0]     chk_data;
   logic                 chk_valid;
   logic                 clr_cnt;
   logic                 locked;
   logic [ERR_CNT_W-1:0] err_cnt;
   logic                 err_pulse;

   modport master (
      output enable, inj_err, chk_data, chk_valid, clr_cnt,
      input  gen_data, gen_valid, locked, err_cnt, err_pulse
   );

   modport slave (
      input  enable, inj_err, chk_data, chk_valid, clr_cnt,
      output gen_data, gen_valid, locked, err_cnt, err_pulse
   );
endinterface

// File: rtl/prbs_gen_chk.sv
// ---------------------------------------------------------------------------
// prbs_gen_chk
// Parametrised PRBS generator plus an independent self-synchronising checker
// sharing one clock. The generator can be looped back into the checker for
// link / BER testing.
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-high reset
//   bus  - prbs_gen_chk_if.slave (generator and checker signals)
// Polynomials (Fibonacci, fb = s[ORDER-1] ^ s[TAP-1]):
//   7: x^7+x^6+1   9: x^9+x^5+1   15: x^15+x^14+1
//   23: x^23+x^18+1   31: x^31+x^28+1
// ---------------------------------------------------------------------------
module prbs_gen_chk #(
   parameter int                    PRBS_ORDER = 9,
   parameter int                    WIDTH      = 1,
   parameter logic [PRBS_ORDER-1:0] SEED       = '1,
   parameter int                    ERR_CNT_W  = 16,
   parameter int                    LOCK_CNT   = 16,
   parameter int                    UNLOCK_THR = 4
) (
   input  logic          clk,
   input  logic          rst,
   prbs_gen_chk_if.slave bus
);

   localparam int TAP = (PRBS_ORDER == 7)  ? 6  :
                        (PRBS_ORDER == 9)  ? 5  :
                        (PRBS_ORDER == 15) ? 14 :
                        (PRBS_ORDER == 23) ? 18 :
                        (PRBS_ORDER == 31) ? 28 : 0;

   localparam int NERR_W = $clog2(WIDTH + 1);
   localparam int GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int BAD_W  = $clog2(UNLOCK_THR + 1);
   // One spare bit so the sum of count and word errors cannot wrap
   localparam int SUM_W  = ((ERR_CNT_W > NERR_W) ? ERR_CNT_W : NERR_W) + 1;
   localparam logic [SUM_W-1:0] ERR_MAX = {{(SUM_W-ERR_CNT_W){1'b0}}, {ERR_CNT_W{1'b1}}};

   // Elaboration-time parameter guards
   if (TAP == 0) begin : g_bad_order
      $error("prbs_gen_chk: PRBS_ORDER must be 7, 9, 15, 23 or 31");
   end
   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("prbs_gen_chk: WIDTH must be 1..32");
   end
   if (SEED == '0) begin : g_bad_seed
      $error("prbs_gen_chk: SEED must be non-zero");
   end
   if (LOCK_CNT < 1 || UNLOCK_THR < 1) begin : g_bad_thr
      $error("prbs_gen_chk: LOCK_CNT and UNLOCK_THR must be >= 1");
   end

   function automatic logic lfsr_fb(input logic [PRBS_ORDER-1:0] s);
      return s[PRBS_ORDER-1] ^ s[TAP-1];
   endfunction

   // -----------------------------------------------------------------------
   // Generator
   // -----------------------------------------------------------------------
   logic [PRBS_ORDER-1:0] gen_s_reg, gen_s_next;
   logic [WIDTH-1:0]      gen_word, inj_mask, gen_data_reg;
   logic                  gen_valid_reg, inj_pend_reg;

   // WIDTH LFSR steps per word; the first step's bit lands in the MSB
   always_comb begin
      gen_s_next = gen_s_reg;
      gen_word   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         gen_word[WIDTH-1-i] = lfsr_fb(gen_s_next);
         gen_s_next          = {gen_s_next[PRBS_ORDER-2:0], gen_word[WIDTH-1-i]};
      end
      // Injection only touches the output word, never the LFSR state
      inj_mask            = '0;
      inj_mask[WIDTH-1]   = inj_pend_reg | bus.inj_err;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gen_s_reg     <= SEED;
         gen_data_reg  <= '0;
         gen_valid_reg <= 1'b0;
         inj_pend_reg  <= 1'b0;
      end else if (bus.enable) begin
         gen_s_reg     <= gen_s_next;
         gen_data_reg  <= gen_word ^ inj_mask;
         gen_valid_reg <= 1'b1;
         inj_pend_reg  <= 1'b0;
      end else begin
         gen_valid_reg <= 1'b0;
         // Any number of pulses while idle collapse into a single error
         inj_pend_reg  <= inj_pend_reg | bus.inj_err;
      end
   end

   assign bus.gen_data  = gen_data_reg;
   assign bus.gen_valid = gen_valid_reg;

   // -----------------------------------------------------------------------
   // Checker
   // -----------------------------------------------------------------------
   typedef enum logic {SEARCH, LOCKED} chk_state_t;

   chk_state_t            state_reg, state_next;
   logic [PRBS_ORDER-1:0] chk_r_reg, chk_r_next, chk_r_walk;
   logic [WIDTH-1:0]      pred_word, err_bits;
   logic [NERR_W-1:0]     nerr;
   logic                  word_good;
   logic [GOOD_W-1:0]     good_run_reg, good_run_next;
   logic [BAD_W-1:0]      bad_run_reg, bad_run_next;
   logic [ERR_CNT_W-1:0]  err_cnt_reg, err_cnt_next, err_base;
   logic [SUM_W-1:0]      err_sum;
   logic                  err_pulse_reg, err_pulse_next;

   // Bit-serial prediction. In SEARCH the received bit is shifted in so the
   // register self-synchronises; in LOCKED it free-runs on its own prediction
   // so line errors cannot corrupt the reference.
   always_comb begin
      chk_r_walk = chk_r_reg;
      pred_word  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pred_word[WIDTH-1-i] = lfsr_fb(chk_r_walk);
         chk_r_walk = {chk_r_walk[PRBS_ORDER-2:0],
                       (state_reg == SEARCH) ? bus.chk_data[WIDTH-1-i] : pred_word[WIDTH-1-i]};
      end
   end

   assign err_bits  = bus.chk_data ^ pred_word;
   // A zero register would accept the all-zero stream forever, so reject it
   assign word_good = (err_bits == '0) && (chk_r_walk != '0);

   always_comb begin
      nerr = '0;
      for (int i = 0; i < WIDTH; i++) begin
         nerr = nerr + NERR_W'(err_bits[i]);
      end
   end

   always_comb begin
      state_next     = state_reg;
      chk_r_next     = chk_r_reg;
      good_run_next  = good_run_reg;
      bad_run_next   = bad_run_reg;
      err_pulse_next = 1'b0;
      // Clear takes effect first; an errored word in the same cycle still counts
      err_base       = bus.clr_cnt ? '0 : err_cnt_reg;
      err_sum        = SUM_W'(err_base) + SUM_W'(nerr);
      err_cnt_next   = err_base;

      if (bus.chk_valid) begin
         chk_r_next = chk_r_walk;
         case (state_reg)
            SEARCH: begin
               if (word_good) begin
                  if (good_run_reg == GOOD_W'(LOCK_CNT - 1)) begin
                     state_next    = LOCKED;
                     good_run_next = '0;
                     bad_run_next  = '0;
                  end else begin
                     good_run_next = good_run_reg + 1'b1;
                  end
               end else begin
                  good_run_next = '0;
               end
            end
            LOCKED: begin
               err_cnt_next   = (err_sum > ERR_MAX) ? '1 : err_sum[ERR_CNT_W-1:0];
               err_pulse_next = (nerr != '0);
               if (nerr != '0) begin
                  if (bad_run_reg == BAD_W'(UNLOCK_THR - 1)) begin
                     state_next    = SEARCH;
                     good_run_next = '0;
                     bad_run_next  = '0;
                  end else begin
                     bad_run_next = bad_run_reg + 1'b1;
                  end
               end else begin
                  bad_run_next = '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= SEARCH;
         chk_r_reg     <= '0;
         good_run_reg  <= '0;
         bad_run_reg   <= '0;
         err_cnt_reg   <= '0;
         err_pulse_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         chk_r_reg     <= chk_r_next;
         good_run_reg  <= good_run_next;
         bad_run_reg   <= bad_run_next;
         err_cnt_reg   <= err_cnt_next;
         err_pulse_reg <= err_pulse_next;
      end
   end

   assign bus.locked    = (state_reg == LOCKED);
   assign bus.err_cnt   = err_cnt_reg;
   assign bus.err_pulse = err_pulse_reg;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// ---------------------------------------------------------------------------
// tb_prbs_gen_chk
// Three instances: A (PRBS9, 8-bit words, 16-bit counter), B (PRBS9, 1-bit),
// C (PRBS9, 8-bit words, 4-bit counter, high unlock threshold).
// Generators loop back into their own checkers with an optional XOR mask.
// ---------------------------------------------------------------------------
module tb_prbs_gen_chk;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   prbs_gen_chk_if #(.WIDTH(8), .ERR_CNT_W(16)) a_if ();
   prbs_gen_chk_if #(.WIDTH(1), .ERR_CNT_W(16)) b_if ();
   prbs_gen_chk_if #(.WIDTH(8), .ERR_CNT_W(4))  c_if ();

   prbs_gen_chk #(.PRBS_ORDER(9), .WIDTH(8), .ERR_CNT_W(16), .LOCK_CNT(16), .UNLOCK_THR(4))
      dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
   prbs_gen_chk #(.PRBS_ORDER(9), .WIDTH(1), .ERR_CNT_W(16), .LOCK_CNT(16), .UNLOCK_THR(4))
      dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));
   prbs_gen_chk #(.PRBS_ORDER(9), .WIDTH(8), .ERR_CNT_W(4), .LOCK_CNT(16), .UNLOCK_THR(100))
      dut_c (.clk(clk), .rst(rst), .bus(c_if.slave));

   // Loopback paths
   logic [7:0] a_corrupt = 8'h00;
   logic [7:0] c_corrupt = 8'h00;
   logic       a_zero    = 1'b0;

   assign a_if.chk_data  = a_zero ? 8'h00 : (a_if.gen_data ^ a_corrupt);
   assign a_if.chk_valid = a_zero | a_if.gen_valid;
   assign b_if.chk_data  = b_if.gen_data;
   assign b_if.chk_valid = b_if.gen_valid;
   assign c_if.chk_data  = c_if.gen_data ^ c_corrupt;
   assign c_if.chk_valid = c_if.gen_valid;

   typedef struct {
      logic       en;
      logic       inj;
      logic       exp_valid;
      logic [7:0] exp_data;
   } gen_vec_t;

   gen_vec_t gv [9];
   logic     bb [0:1099];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   // Ticks until 'locked' of the selected instance rises, bounded by budget
   task automatic wait_lock(input int sel, input int budget, output int n);
      n = 0;
      while (n < budget && !((sel == 0) ? a_if.locked : c_if.locked)) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n, pulses, run, maxrun, mism;
      logic [31:0] first32;

      a_if.enable = 1'b0; a_if.inj_err = 1'b0; a_if.clr_cnt = 1'b0;
      b_if.enable = 1'b0; b_if.inj_err = 1'b0; b_if.clr_cnt = 1'b0;
      c_if.enable = 1'b0; c_if.inj_err = 1'b0; c_if.clr_cnt = 1'b0;

      // Hand-derived PRBS9 words from SEED=9'h1FF: 07 BE 2E 64
      gv[0] = '{1'b1, 1'b0, 1'b1, 8'h07};
      gv[1] = '{1'b0, 1'b0, 1'b0, 8'h07};
      gv[2] = '{1'b0, 1'b1, 1'b0, 8'h07};
      gv[3] = '{1'b1, 1'b0, 1'b1, 8'h3E};  // BE with MSB inverted
      gv[4] = '{1'b0, 1'b1, 1'b0, 8'h3E};
      gv[5] = '{1'b0, 1'b1, 1'b0, 8'h3E};  // two pulses -> one error
      gv[6] = '{1'b1, 1'b0, 1'b1, 8'hAE};  // 2E with MSB inverted
      gv[7] = '{1'b1, 1'b0, 1'b1, 8'h64};  // LFSR untouched by injection
      gv[8] = '{1'b0, 1'b0, 1'b0, 8'h64};

      // ---- reset state ----
      repeat (3) tick();
      check("rst_a_locked",    a_if.locked, 0);
      check("rst_a_err_cnt",   a_if.err_cnt, 0);
      check("rst_a_err_pulse", a_if.err_pulse, 0);
      check("rst_a_gen_valid", a_if.gen_valid, 0);
      check("rst_a_gen_data",  a_if.gen_data, 0);
      check("rst_c_err_cnt",   c_if.err_cnt, 0);
      rst = 1'b0;

      // ---- generator vector table (instance A) ----
      for (int i = 0; i < 9; i++) begin
         a_if.enable  = gv[i].en;
         a_if.inj_err = gv[i].inj;
         tick();
         check($sformatf("gen_vec%0d_valid", i), a_if.gen_valid, gv[i].exp_valid);
         check($sformatf("gen_vec%0d_data", i),  a_if.gen_data,  gv[i].exp_data);
      end
      a_if.inj_err = 1'b0;

      // ---- 1-bit generator: sequence, period, zero runs (instance B) ----
      b_if.enable = 1'b1;
      for (int i = 0; i < 1100; i++) begin
         tick();
         bb[i] = b_if.gen_data[0];
      end
      first32 = '0;
      for (int i = 0; i < 32; i++) first32 = {first32[30:0], bb[i]};
      check("b_first32_bits", first32, 32'h07BE2E64);
      mism = 0;
      for (int i = 0; i < 589; i++) if (bb[i] !== bb[i+511]) mism++;
      check("b_period511_mismatches", mism, 0);
      mism = 0;
      for (int i = 0; i < 511; i++) if (bb[i] !== bb[i+1]) mism++;
      check("b_not_constant", (mism > 100), 1);
      run = 0; maxrun = 0;
      for (int i = 0; i < 1100; i++) begin
         if (bb[i] == 1'b0) begin
            run++;
            if (run > maxrun) maxrun = run;
         end else run = 0;
      end
      check("b_max_zero_run", maxrun, 8);
      check("b_loop_locked",  b_if.locked, 1);
      check("b_loop_err_cnt", b_if.err_cnt, 0);

      // ---- all-zero stream never locks (instance A) ----
      a_zero = 1'b1;
      a_if.enable = 1'b1;
      n = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (a_if.locked) n++;
      end
      check("zero_stream_lock_cycles", n, 0);
      check("zero_stream_err_cnt", a_if.err_cnt, 0);

      // ---- loopback lock and clean run ----
      a_zero = 1'b0;
      wait_lock(0, 60, n);
      check("a_lock_time_in_range", (n >= 16 && n <= 40), 1);
      pulses = 0;
      for (int i = 0; i < 10000; i++) begin
         tick();
         if (a_if.err_pulse) pulses++;
      end
      check("clean_run_pulses",  pulses, 0);
      check("clean_run_err_cnt", a_if.err_cnt, 0);
      check("clean_run_locked",  a_if.locked, 1);

      // ---- single injected error ----
      a_if.inj_err = 1'b1;
      tick();
      a_if.inj_err = 1'b0;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (a_if.err_pulse) pulses++;
      end
      check("inj1_pulses",  pulses, 1);
      check("inj1_err_cnt", a_if.err_cnt, 1);
      check("inj1_locked",  a_if.locked, 1);

      a_if.clr_cnt = 1'b1;
      tick();
      a_if.clr_cnt = 1'b0;
      check("clr_err_cnt", a_if.err_cnt, 0);

      // ---- three spaced injections ----
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         a_if.inj_err = 1'b1;
         tick();
         a_if.inj_err = 1'b0;
         if (a_if.err_pulse) pulses++;
         for (int i = 0; i < 100; i++) begin
            tick();
            if (a_if.err_pulse) pulses++;
         end
      end
      check("inj3_pulses",  pulses, 3);
      check("inj3_err_cnt", a_if.err_cnt, 3);
      check("inj3_locked",  a_if.locked, 1);

      // ---- four fully inverted words force unlock ----
      a_if.clr_cnt = 1'b1;
      tick();
      a_if.clr_cnt = 1'b0;
      a_corrupt = 8'hFF;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("inv_word%0d_locked", k), a_if.locked, (k < 3));
         check($sformatf("inv_word%0d_pulse", k),  a_if.err_pulse, 1);
      end
      a_corrupt = 8'h00;
      check("inv4_err_cnt", a_if.err_cnt, 32);
      wait_lock(0, 40, n);
      check("relock_words", n, 16);
      check("relock_err_cnt_held", a_if.err_cnt, 32);

      // ---- reset mid-lock discards a pending injection ----
      a_if.enable  = 1'b0;
      a_if.inj_err = 1'b1;
      tick();
      a_if.inj_err = 1'b0;
      rst = 1'b1;
      tick();
      check("midrst_locked",    a_if.locked, 0);
      check("midrst_err_cnt",   a_if.err_cnt, 0);
      check("midrst_gen_valid", a_if.gen_valid, 0);
      check("midrst_gen_data",  a_if.gen_data, 0);
      rst = 1'b0;
      a_if.enable = 1'b1;
      tick();
      check("midrst_word0", a_if.gen_data, 8'h07);
      tick();
      check("midrst_word1", a_if.gen_data, 8'hBE);

      // ---- saturation and clear on 4-bit counter (instance C) ----
      c_if.enable = 1'b1;
      wait_lock(1, 60, n);
      check("c_locked", c_if.locked, 1);
      c_corrupt = 8'hFF;
      tick();
      check("sat_word0_cnt", c_if.err_cnt, 8);
      tick();
      check("sat_word1_cnt", c_if.err_cnt, 15);
      tick();
      check("sat_word2_cnt", c_if.err_cnt, 15);
      check("sat_locked",    c_if.locked, 1);
      c_corrupt = 8'h00;
      c_if.clr_cnt = 1'b1;
      tick();
      check("sat_clr_cnt", c_if.err_cnt, 0);
      c_corrupt = 8'h81;
      tick();
      check("clr_with_2err_cnt", c_if.err_cnt, 2);
      c_if.clr_cnt = 1'b0;
      c_corrupt = 8'h00;
      tick();
      check("clr_hold_cnt",    c_if.err_cnt, 2);
      check("clr_hold_locked", c_if.locked, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prbs_gen_chk.md
Name: prbs_gen_chk

Overview:
Parametrised PRBS pattern generator and matching self-synchronising checker, used in the link/BER test path.
- Generalises the single-bit PRBS9 source: selectable polynomial order, WIDTH bits per clock, and single-bit error injection.
- The checker has its own lock state machine and a saturating bit-error counter.
- The generator and checker share the clock but are otherwise independent, so the generator can loop back into the checker.

Parameters:
PRBS_ORDER, 9, polynomial: 7 -> x^7+x^6+1, 9 -> x^9+x^5+1, 15 -> x^15+x^14+1, 23 -> x^23+x^18+1, 31 -> x^31+x^28+1; any other value is a synthesis-time error.
WIDTH, 1, bits produced or checked per clock, 1..32.
SEED, all ones (PRBS_ORDER bits), generator reset state; must be non-zero.
ERR_CNT_W, 16, error counter width.
LOCK_CNT, 16, consecutive good words needed to lock (>=1).
UNLOCK_THR, 4, consecutive errored words that force a return to search (>=1).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  generator advances one WIDTH-bit word per cycle while high
inj_err  in  1  pulse: invert bit WIDTH-1 of the next generated word
gen_data  out  WIDTH  generated word; bit WIDTH-1 is first in time
gen_valid  out  1  gen_data holds a new word
chk_data  in  WIDTH  received word, bit WIDTH-1 first in time
chk_valid  in  1  chk_data is valid this cycle
clr_cnt  in  1  clear err_cnt
locked  out  1  checker is in LOCKED state
err_cnt  out  ERR_CNT_W  saturating count of errored bits seen while LOCKED
err_pulse  out  1  last checked word contained at least one error (LOCKED only)

Behaviour:
- LFSR step (Fibonacci), state s[ORDER-1:0]:
  - fb = s[ORDER-1] ^ s[TAP-1], where TAP is the lower exponent of the polynomial.
  - s <= {s[ORDER-2:0], fb}; the emitted bit is fb.
  - One word = WIDTH successive steps; the first step's bit goes to bit WIDTH-1.
- Generator:
  - Reset: s=SEED, gen_data=0, gen_valid=0.
  - On a cycle with enable=1: the next word is registered into gen_data, s advances WIDTH steps, and gen_valid=1 the following cycle. Latency is 1 cycle.
  - enable=0: s and gen_data hold, gen_valid=0.
  - inj_err is captured into a pending flag.
    - The flag applies to the next enable=1 word: bit WIDTH-1 is XOR'ed with 1 and the flag clears.
    - The LFSR state is never altered by injection.
    - Multiple pulses before that word collapse to one error.
- Checker state register r[ORDER-1:0]; reset r=0.
- Checker states: SEARCH, LOCKED. Reset enters SEARCH with good_run=0, bad_run=0, err_cnt=0, locked=0, err_pulse=0.
- SEARCH, on chk_valid:
  - Each received bit is predicted from r, and the received bit (not the prediction) is shifted into r.
  - The word is good if every bit matches and the final r is non-zero; the all-zero stream never locks.
  - Good word: good_run+1. Bad word: good_run=0.
  - When good_run reaches LOCK_CNT, go to LOCKED and set bad_run=0.
- LOCKED, on chk_valid:
  - r free-runs on its own prediction; received bits are ignored for state.
  - nerr = popcount(chk_data ^ predicted word).
  - err_cnt += nerr, saturating at all ones.
  - err_pulse = (nerr!=0), registered, high for exactly one cycle per errored word.
  - Errored word: bad_run+1. Clean word: bad_run=0.
  - When bad_run reaches UNLOCK_THR, go to SEARCH with good_run=0. The errors of that word are still counted.
- chk_valid=0: no state change anywhere in the checker; err_pulse=0.
- locked is registered and reflects the state after the update, 1 cycle after the deciding word.
- clr_cnt:
  - Zeroes err_cnt next cycle.
  - If it coincides with an errored word, err_cnt = nerr of that word; the clear applies first and the increment still counts.
  - It does not affect the lock state.
- err_cnt holds its value through SEARCH and is not incremented there.
- rst mid-operation: all registers return to their reset values next cycle, any pending inj_err is discarded, and locking restarts.

Test Plan:
1. PRBS_ORDER=9, WIDTH=1, enable=1 after reset -> gen_data bits 0,0,0,0,0,1,1,1 on the first 8 valid cycles; the sequence repeats with period 511; no all-zero run longer than 8.
2. PRBS_ORDER=9, WIDTH=8, gen looped to chk, LOCK_CNT=16 -> first word 8'h07; locked rises 1 cycle after the 16th (or later) valid word; err_cnt stays 0 over 10000 words.
3. Locked loopback, one inj_err pulse -> exactly one err_pulse cycle, err_cnt=1, locked stays 1; 3 pulses spaced 100 words apart -> err_cnt=3.
4. Locked, chk_data forced to ~expected for 4 words (WIDTH=8, UNLOCK_THR=4) -> err_cnt=32; locked falls after the 4th word; relocks after 16 clean words.
5. ERR_CNT_W=4, continuous inversion while locked with UNLOCK_THR large -> err_cnt saturates at 4'hF; clr_cnt -> 0 next cycle; clr_cnt together with a 2-error word -> 2.
6. chk_data all zero with chk_valid=1 -> never locks. enable toggled 0/1 -> gen_data holds and the sequence resumes without skipping. rst mid-lock -> locked=0, err_cnt=0, generator restarts at SEED.
